// File: rtl/mem_wb_pipe_pkg.sv
// mem_wb_pipe_pkg: In_Ctrl field positions, control width and load-mode encodings
package mem_wb_pipe_pkg;
  localparam int CTRL_W        = 6;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_M2R_LO   = 1;
  localparam int CTRL_HALF     = 3;
  localparam int CTRL_SIGNED   = 5;
  localparam int LM_W          = 3;
  localparam int LMB_HALF      = 0;
  localparam int LMB_BYTE      = 1;
  localparam int LMB_SIGNED    = 2;
  typedef enum logic [LM_W-1:0] {
    LM_WORD   = 3'b000,
    LM_HALF_U = 3'b001,
    LM_BYTE_U = 3'b010,
    LM_HALF_S = 3'b101,
    LM_BYTE_S = 3'b110
  } load_mode_e;
endpackage

// File: rtl/mem_wb_pipe_load_fmt.sv
// load_fmt: byte/half lane select with sign or zero extension; byte wins over half
module load_fmt
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_addr,
  input  logic [LM_W-1:0]   i_mode,
  output logic [DATA_W-1:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sx;
  always_comb begin
    w_byte = i_data[{i_addr, 3'b000} +: 8];
    w_half = i_data[{i_addr[1], 4'b0000} +: 16];
    w_sx   = i_mode[LMB_SIGNED] & (i_mode[LMB_BYTE] ? w_byte[7] : w_half[15]);
    o_data = i_mode[LMB_BYTE] ? {{(DATA_W-8){w_sx}}, w_byte} :
             i_mode[LMB_HALF] ? {{(DATA_W-16){w_sx}}, w_half} : i_data;
  end
endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: STAGES-deep MEM->WB register pipeline with stall, flush and bubble insertion.
// Define MEM_WB_LOADFMT_EN to format load data in stage 0 instead of in write-back.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int STAGES = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              In_Valid,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Read,
  input  logic [DATA_W-1:0] In_PCAddResult,
  input  logic [DATA_W-1:0] In_ALUResult,
  input  logic [REG_W-1:0]  In_RegDst,
  output logic              Out_Valid,
  output logic              Out_RegWrite,
  output logic [1:0]        Out_MemToReg,
  output logic [LM_W-1:0]   Out_LoadMode,
  output logic [DATA_W-1:0] Out_Read,
  output logic [DATA_W-1:0] Out_PCAddResult,
  output logic [DATA_W-1:0] Out_ALUResult,
  output logic [REG_W-1:0]  Out_RegDst
);
  localparam int ST_W = 4 + LM_W + REG_W + 3 * DATA_W;
  logic [DATA_W-1:0] w_read;
  logic              w_rw;
`ifdef MEM_WB_LOADFMT_EN
  load_fmt #(.DATA_W(DATA_W)) u_fmt (
    .i_data(In_Read),
    .i_addr(In_ALUResult[1:0]),
    .i_mode(In_Ctrl[CTRL_SIGNED:CTRL_HALF]),
    .o_data(w_read)
  );
`else
  assign w_read = In_Read;
`endif
  // Each stage holds {valid, regwrite, memtoreg, loadmode, regdst, read, pc4, alu} as one word
  for (genvar s = 0; s < STAGES; s++) begin : g_st
    logic [ST_W-1:0] r_st;
    logic [ST_W-1:0] w_st;
    if (s == 0) begin : g_src
      assign w_st = In_Valid ? {1'b1, In_Ctrl[CTRL_REGWRITE], In_Ctrl[CTRL_M2R_LO +: 2],
                                In_Ctrl[CTRL_SIGNED:CTRL_HALF], In_RegDst, w_read,
                                In_PCAddResult, In_ALUResult} : '0;
    end else begin : g_src
      assign w_st = g_st[s-1].r_st;
    end
    always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) r_st <= '0;
      else if (Flush) r_st <= '0;
      else if (!Stall) r_st <= w_st;
  end
  assign {Out_Valid, w_rw, Out_MemToReg, Out_LoadMode, Out_RegDst, Out_Read,
          Out_PCAddResult, Out_ALUResult} = g_st[STAGES-1].r_st;
  assign Out_RegWrite = w_rw & Out_Valid & (|Out_RegDst);
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: randomized and directed checks of a 1-stage and a 3-stage instance against a queue model
module tb_mem_wb_pipe;
  localparam int OW = 108;
  logic Clk = 0, Rst_n = 0, Stall = 0, Flush = 0, In_Valid = 0;
  logic [5:0]  In_Ctrl = '0;
  logic [31:0] In_Read = '0, In_PCAddResult = '0, In_ALUResult = '0;
  logic [4:0]  In_RegDst = '0;
  logic a_v, a_rw, b_v, b_rw;
  logic [1:0]  a_m2r, b_m2r;
  logic [2:0]  a_lm, b_lm;
  logic [31:0] a_rd, a_pc, a_alu, b_rd, b_pc, b_alu;
  logic [4:0]  a_dst, b_dst;
  logic [OW-1:0] o1, o3;
  logic [OW-1:0] q1[$], q3[$];
  int n_chk = 0, n_fail = 0;

  always #5 Clk = ~Clk;

  mem_wb_pipe #(.DATA_W(32), .REG_W(5), .STAGES(1)) u_dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .In_Valid(In_Valid),
    .In_Ctrl(In_Ctrl), .In_Read(In_Read), .In_PCAddResult(In_PCAddResult),
    .In_ALUResult(In_ALUResult), .In_RegDst(In_RegDst), .Out_Valid(a_v),
    .Out_RegWrite(a_rw), .Out_MemToReg(a_m2r), .Out_LoadMode(a_lm), .Out_Read(a_rd),
    .Out_PCAddResult(a_pc), .Out_ALUResult(a_alu), .Out_RegDst(a_dst));

  mem_wb_pipe #(.DATA_W(32), .REG_W(5), .STAGES(3)) u_dut3 (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .In_Valid(In_Valid),
    .In_Ctrl(In_Ctrl), .In_Read(In_Read), .In_PCAddResult(In_PCAddResult),
    .In_ALUResult(In_ALUResult), .In_RegDst(In_RegDst), .Out_Valid(b_v),
    .Out_RegWrite(b_rw), .Out_MemToReg(b_m2r), .Out_LoadMode(b_lm), .Out_Read(b_rd),
    .Out_PCAddResult(b_pc), .Out_ALUResult(b_alu), .Out_RegDst(b_dst));

  assign o1 = {a_v, a_rw, a_m2r, a_lm, a_dst, a_rd, a_pc, a_alu};
  assign o3 = {b_v, b_rw, b_m2r, b_lm, b_dst, b_rd, b_pc, b_alu};

  // What write-back should see for one accepted MEM-side instruction
  function automatic logic [OW-1:0] mk(logic v, logic [5:0] c, logic [4:0] rd,
                                       logic [31:0] rdata, logic [31:0] pc, logic [31:0] alu);
    logic [31:0] d = rdata;
`ifdef MEM_WB_LOADFMT_EN
    if (c[4]) begin
      d = (rdata >> (8 * alu[1:0])) & 32'hFF;
      if (c[5] && d[7]) d = d | 32'hFFFFFF00;
    end else if (c[3]) begin
      d = (rdata >> (16 * alu[1])) & 32'hFFFF;
      if (c[5] && d[15]) d = d | 32'hFFFF0000;
    end
`endif
    if (!v) return '0;
    return {1'b1, c[0] && (rd != 0), c[2:1], c[5:3], rd, d, pc, alu};
  endfunction

  function automatic logic [OW-1:0] exp_of(input logic [OW-1:0] q[$], input int n);
    return (q.size() >= n) ? q[q.size() - n] : '0;
  endfunction

  task automatic drive(logic v, logic [5:0] c, logic [4:0] rd, logic [31:0] alu);
    In_Valid = v; In_Ctrl = c; In_RegDst = rd; In_ALUResult = alu;
    In_Read = $urandom; In_PCAddResult = $urandom;
  endtask

  task automatic drive_rand();
    drive(1'($urandom_range(0, 3) != 0), 6'($urandom), 5'($urandom), $urandom);
  endtask

  // One rising edge: the model records each unstalled capture, in order, and forgets on flush
  task automatic cycle();
    logic [OW-1:0] e;
    @(posedge Clk);
    if (Rst_n) begin
      if (Flush) begin q1.delete(); q3.delete(); end
      else if (!Stall) begin
        e = mk(In_Valid, In_Ctrl, In_RegDst, In_Read, In_PCAddResult, In_ALUResult);
        q1.push_back(e); q3.push_back(e);
        if (q1.size() > 8) begin void'(q1.pop_front()); void'(q3.pop_front()); end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (o1 !== '0) begin n_fail++; $display("FAIL reset_s1 got=%h exp=0", o1); end
    n_chk++; if (o3 !== '0) begin n_fail++; $display("FAIL reset_s3 got=%h exp=0", o3); end
    @(negedge Clk); Rst_n = 1;
  endtask

  task automatic test_basic();
    drive(1, 6'b000001, 5'd8, 32'h1234);
    cycle();
    n_chk++;
    if ({a_v, a_rw, a_dst, a_alu} !== {1'b1, 1'b1, 5'd8, 32'h1234}) begin
      n_fail++; $display("FAIL basic_s1 got v=%b rw=%b dst=%0d alu=%h exp v=1 rw=1 dst=8 alu=1234", a_v, a_rw, a_dst, a_alu);
    end
    n_chk++; if (o1 !== exp_of(q1, 1)) begin n_fail++; $display("FAIL basic_model got=%h exp=%h", o1, exp_of(q1, 1)); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      drive_rand();
      Stall = ($urandom_range(0, 4) == 0);
      Flush = ($urandom_range(0, 9) == 0);
      cycle();
      n_chk++; if (o1 !== exp_of(q1, 1)) begin n_fail++; $display("FAIL random_s1 i=%0d got=%h exp=%h", i, o1, exp_of(q1, 1)); end
      n_chk++; if (o3 !== exp_of(q3, 3)) begin n_fail++; $display("FAIL random_s3 i=%0d got=%h exp=%h", i, o3, exp_of(q3, 3)); end
    end
    Stall = 0; Flush = 0;
  endtask

  task automatic test_stall3();
    logic [31:0] want [7];
    logic        wv   [7];
    want = '{0, 0, 0, 0, 32'hA0, 32'hB0, 32'hC0};
    wv   = '{0, 0, 0, 0, 1, 1, 1};
    Flush = 1; cycle(); Flush = 0;
    for (int e = 1; e <= 6; e++) begin
      Stall = (e == 2);
      if (e == 1) drive(1, 6'b000001, 5'd3, 32'hA0);
      else if (e <= 3) drive(1, 6'b000001, 5'd4, 32'hB0);
      else if (e == 4) drive(1, 6'b000001, 5'd5, 32'hC0);
      else drive(0, 6'b0, 5'd0, 32'h0);
      cycle();
      if (e >= 3) begin
        n_chk++;
        if ({b_v, b_alu} !== {wv[e], want[e]}) begin
          n_fail++; $display("FAIL stall3 edge=%0d got v=%b alu=%h exp v=%b alu=%h", e, b_v, b_alu, wv[e], want[e]);
        end
      end
      n_chk++; if (o3 !== exp_of(q3, 3)) begin n_fail++; $display("FAIL stall3_model edge=%0d got=%h exp=%h", e, o3, exp_of(q3, 3)); end
    end
    Stall = 0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin drive(1, 6'($urandom) | 6'b1, 5'($urandom_range(1, 31)), $urandom); cycle(); end
    Flush = 1; Stall = 1; drive(1, 6'b000001, 5'd9, $urandom);
    cycle();
    Flush = 0; Stall = 0;
    n_chk++; if (o1 !== '0) begin n_fail++; $display("FAIL flush_s1 got=%h exp=0", o1); end
    n_chk++; if (o3 !== '0) begin n_fail++; $display("FAIL flush_s3 got=%h exp=0", o3); end
  endtask

  task automatic test_rd0();
    drive(1, 6'b000001, 5'd0, $urandom);
    cycle();
    n_chk++; if ({a_v, a_rw} !== 2'b10) begin n_fail++; $display("FAIL rd0 got v=%b rw=%b exp v=1 rw=0", a_v, a_rw); end
    n_chk++; if (o1 !== exp_of(q1, 1)) begin n_fail++; $display("FAIL rd0_model got=%h exp=%h", o1, exp_of(q1, 1)); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin drive(1, 6'b000001, 5'($urandom_range(1, 31)), $urandom); cycle(); end
    @(negedge Clk); #2 Rst_n = 0; #1;
    q1.delete(); q3.delete();
    n_chk++; if (o1 !== '0) begin n_fail++; $display("FAIL areset_s1 got=%h exp=0", o1); end
    n_chk++; if (o3 !== '0) begin n_fail++; $display("FAIL areset_s3 got=%h exp=0", o3); end
    #1 Rst_n = 1;
    drive(1, 6'b000011, 5'd7, 32'h55);
    for (int e = 1; e <= 3; e++) begin
      cycle();
      drive(0, 6'b0, 5'd0, 32'h0);
      n_chk++;
      if (b_v !== (e == 3)) begin n_fail++; $display("FAIL areset_lat edge=%0d got v=%b exp v=%b", e, b_v, e == 3); end
      n_chk++; if (o3 !== exp_of(q3, 3)) begin n_fail++; $display("FAIL areset_model edge=%0d got=%h exp=%h", e, o3, exp_of(q3, 3)); end
    end
  endtask

`ifdef MEM_WB_LOADFMT_EN
  task automatic test_fmt();
    drive(1, 6'b110000, 5'd2, 32'h0000_0012); In_Read = 32'h80FF7F01;
    cycle();
    n_chk++; if (a_rd !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL fmt_signed got=%h exp=ffffffff", a_rd); end
    drive(1, 6'b010000, 5'd2, 32'h0000_0012); In_Read = 32'h80FF7F01;
    cycle();
    n_chk++; if (a_rd !== 32'h000000FF) begin n_fail++; $display("FAIL fmt_unsigned got=%h exp=000000ff", a_rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_stall3();
    test_flush();
    test_rd0();
    test_async_reset();
`ifdef MEM_WB_LOADFMT_EN
    test_fmt();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of the read-data, PC+4 and ALU-result datapaths.
REQ-002 Parameter REG_W, default 5, width of the destination-register index.
REQ-003 Parameter STAGES, default 1, range 1..4, number of register stages between MEM and WB.
REQ-004 Port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port Rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port Stall  input  1  hold all stages when high.
REQ-007 Port Flush  input  1  convert all stages to bubbles when high.
REQ-008 Port In_Valid  input  1  MEM-side instruction present.
REQ-009 Port In_Ctrl  input  6  control: [0] RegWrite, [2:1] MemToReg, [3] half, [4] byte, [5] signed.
REQ-010 Port In_Read, In_PCAddResult, In_ALUResult  input  DATA_W each  memory read data, PC+4, ALU result.
REQ-011 Port In_RegDst  input  REG_W  destination register index.
REQ-012 Port Out_Valid, Out_RegWrite  output  1 each  WB-side valid and qualified write enable.
REQ-013 Port Out_MemToReg  output  2  write-back mux select.
REQ-014 Port Out_LoadMode  output  3  In_Ctrl[5:3] delayed with the data.
REQ-015 Port Out_Read, Out_PCAddResult, Out_ALUResult  output  DATA_W each  delayed datapath values.
REQ-016 Port Out_RegDst  output  REG_W  delayed destination register index.

Function
REQ-017 Stage 0 SHALL capture inputs and stage k SHALL capture stage k-1 on every rising edge with Stall=0 and Flush=0; outputs SHALL be driven directly from stage STAGES-1 registers.
REQ-018 Latency from input to output SHALL be exactly STAGES unstalled cycles.
REQ-019 Stall=1, Flush=0 SHALL hold every stage unchanged, including Out_*.
REQ-020 Flush=1 SHALL clear valid, RegWrite and all data fields to 0 in every stage on that edge; Flush SHALL take priority over Stall.
REQ-021 A capture with In_Valid=0 SHALL store a bubble: valid=0, RegWrite=0, data zeroed.
REQ-022 Out_RegWrite SHALL equal stored RegWrite AND stored valid AND (stored RegDst != 0); register 0 is never written.
REQ-023 Out_MemToReg, Out_LoadMode and Out_RegDst SHALL travel in lock-step with their datapath values through every stage; no field SHALL skip or lag a stage.
REQ-024 Simultaneous Flush and In_Valid=1 SHALL discard the incoming instruction.

Reset
REQ-025 Rst_n=0 SHALL immediately, without a clock edge, force every stage and every output to 0.
REQ-026 Deassertion of Rst_n SHALL take effect on the next rising Clk; the first capture occurs on that edge when Stall=0.
REQ-027 Reset asserted mid-operation SHALL drop all in-flight instructions; no partial stage SHALL survive.

Configuration
REQ-028 Macro MEM_WB_LOADFMT_EN defined: stage 0 SHALL format In_Read before storing it, using In_ALUResult[1:0].
- byte=1: select byte lane ALUResult[1:0].
- half=1: select halfword ALUResult[1].
- Extension: sign-extend if signed=1, else zero-extend.
- byte and half both 0: pass word unchanged; byte takes priority over half.
REQ-029 Macro MEM_WB_LOADFMT_EN undefined: In_Read SHALL pass unformatted and the write-back stage SHALL format using Out_LoadMode; Out_LoadMode SHALL be present in both builds.

Structure
REQ-030 A shared package SHALL hold the In_Ctrl bit-position constants, the control width (6) and the load-mode encodings.
REQ-031 The formatter SHALL be a separate combinational sub-module load_fmt, instantiated only under MEM_WB_LOADFMT_EN.
REQ-032 Stages SHALL be built with a generate loop over STAGES; no per-depth hand-written copies.

Verification
REQ-033 STAGES=1: In_Valid=1, Ctrl=6'b000001, RegDst=5'd8, ALUResult=32'h1234 -> next edge Out_Valid=1, Out_RegWrite=1, Out_RegDst=8, Out_ALUResult=32'h1234.
REQ-034 STAGES=3: Stall=1 during cycle 2 of a three-instruction stream -> the instructions emerge in order on cycles 4, 5 and 6, not 3, 4 and 5; none is lost or duplicated.
REQ-035 Flush=1 together with Stall=1 and a full pipe -> next edge Out_Valid=0, Out_RegWrite=0, all Out_* = 0.
REQ-036 RegDst=0 with RegWrite=1 and In_Valid=1 -> Out_RegWrite=0 while Out_Valid=1.
REQ-037 Macro defined: In_Read=32'h80FF7F01, ALUResult[1:0]=2'b10, byte=1, signed=1 -> Out_Read=32'hFFFFFFFF; signed=0 -> 32'h000000FF.
REQ-038 Rst_n pulsed low between edges with a full pipe -> all outputs 0 immediately; the first post-reset instruction appears STAGES edges after deassertion.
